conv_mac_requant: RTL and testbench
===================================

# conv_mac_requant

Streaming multiply-accumulate and requantisation stage directly upstream of the PWL hard-tanh activation in the HiFi-GAN datapath. Accepts TAPS (sample, weight) pairs per output, accumulates the Q8.24 products plus a Q4.12 bias in a wide accumulator, then rounds and saturates the sum to Q4.12. Output is a valid/ready stream whose `m_data` feeds the activation's `d_in`.

## Interface
- `TAPS`, 3: products accumulated per output; legal range is 1..64.
- `ACC_W`, 40: accumulator width in bits; must be ≥ 33 + $clog2(TAPS).
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_valid`  in  1  input beat valid.
- `s_ready`  out  1  block can accept a beat.
- `s_data`  in  16  signed Q4.12 sample.
- `s_weight`  in  16  signed Q4.12 weight.
- `bias`  in  16  signed Q4.12 bias; sampled on the first beat of each group.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accepts the output word.
- `m_data`  out  16  signed Q4.12 result, unclamped to ±1.0; the activation clamps it.
- `m_sat`  out  1  `m_data` was clipped to the Q4.12 limits; qualified by `m_valid`.

## Operation
- A beat is accepted when `s_valid && s_ready`.
- Product `p = s_data * s_weight` is a signed 32-bit Q8.24 value, sign-extended to ACC_W.
- FSM states:
  - ACCUM: `s_ready`=1, `m_valid`=0. Tap counter `cnt` runs 0..TAPS-1.
    - Beat with `cnt==0`: `acc = (sext(bias) <<< 12) + p`.
    - Any other beat: `acc = acc + p`.
    - Beat with `cnt==TAPS-1`: `cnt` wraps to 0 and the FSM moves to OUT.
  - OUT: `s_ready`=0, `m_valid`=1, and `m_data`/`m_sat` are held stable. On `m_ready` the FSM returns to ACCUM.
- Requantisation when entering OUT, registered into `m_data`:
  - `r = acc + RND`, with RND = 2048 or 0 (see Configuration).
  - `q = r >>> 12`, arithmetic shift.
  - If `q > 32767`: `m_data` = 0x7FFF and `m_sat`=1.
  - If `q < -32768`: `m_data` = 0x8000 and `m_sat`=1.
  - Otherwise: `m_data` = q[15:0] and `m_sat`=0.
- Internal arithmetic never wraps inside ACC_W for legal TAPS and ACC_W.
- TAPS=1: every accepted beat moves the FSM straight to OUT.

## Timing
- Reset values: state=ACCUM, `cnt`=0, `acc`=0, `s_ready`=1, `m_valid`=0, `m_data`=0, `m_sat`=0.
- Latency: `m_valid` rises on the clock edge that accepts the TAPS-th beat, so it is visible the cycle after that beat.
- Throughput: TAPS+1 cycles per output when `s_valid` and `m_ready` are held high.
- `s_ready` is registered and falls together with the `m_valid` rise. No input is accepted in the cycle an output handshakes.
- Backpressure: `m_ready`=0 holds `m_valid`, `m_data` and `m_sat` indefinitely with no change.
- Input gaps: `s_valid`=0 in ACCUM leaves `acc` and `cnt` unchanged; gaps of any length are legal.
- `bias` is sampled only on the first beat of a group. Changes at any other time do not affect the current group.
- Reset asserted mid-group or mid-OUT returns all state to reset values immediately. The partial group is discarded.

## Configuration
- `MAC_ROUND_EN` defined: RND = 2048, i.e. round-half-up toward +∞ at the 12-bit drop.
- `MAC_ROUND_EN` undefined: RND = 0, i.e. truncation (floor).
- FSM, timing and saturation behaviour are identical in both builds.

## Test plan
- Nominal, TAPS=3, bias=0: three beats of 0x1000×0x1000 → `m_data`=0x3000 (3.0) and `m_sat`=0, `m_valid` the cycle after beat 3.
- Bias and negative values: bias=0xF000 (−1.0), beats (0x0800,0x1000), (0x0800,0x1000), (0x0000,0x1000) → `m_data`=0x0000 and `m_sat`=0.
- Saturation: three beats of 0x7FFF×0x7FFF → `m_data`=0x7FFF and `m_sat`=1. Three beats of 0x8000×0x7FFF → `m_data`=0x8000 and `m_sat`=1.
- Rounding, bias=0, beats (0xFFFF,0x0001), (0,0), (0,0): with `MAC_ROUND_EN` → 0x0000; without → 0xFFFF.
  - Additionally, beats (0x0001,0x0800), (0,0), (0,0): with `MAC_ROUND_EN` → 0x0001; without → 0x0000.
- Handshake: hold `m_ready`=0 for 10 cycles with `s_valid`=1 → `s_ready`=0 and `m_data` stable throughout. Then pulse `m_ready` → the next group accumulates cleanly with no beat lost. Random `s_valid` gaps give results identical to the gap-free run.
- Reset: assert `rst` after beat 2 of a group, then send a full fresh group → the result reflects only the fresh group. All outputs read their reset values while `rst` is high.

Source files
------------

// File: rtl/conv_mac_requant.sv
// conv_mac_requant
//   Streaming multiply-accumulate and requantisation stage that feeds the
//   PWL hard-tanh activation. The block takes TAPS (sample, weight) pairs per
//   output. It adds the Q8.24 products and a Q4.12 bias in a wide accumulator,
//   then rounds and saturates the sum back to Q4.12.
//
//   Build option: define MAC_ROUND_EN to round half-up at the 12-bit drop.
//   When it is not defined, the drop truncates (floor).
//
// Ports
//   clk       clock; all state changes on the rising edge
//   rst       asynchronous active-high reset
//   s_valid   input beat valid
//   s_ready   block can accept a beat (registered; high while accumulating)
//   s_data    signed Q4.12 sample
//   s_weight  signed Q4.12 weight
//   bias      signed Q4.12 bias, sampled on the first beat of each group
//   m_valid   output word valid
//   m_ready   downstream accepts the output word
//   m_data    signed Q4.12 result, not clamped to +/-1.0
//   m_sat     m_data was clipped to the Q4.12 limits (qualified by m_valid)
module conv_mac_requant #(
  parameter int TAPS  = 3,
  parameter int ACC_W = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic signed [15:0] s_data,
  input  logic signed [15:0] s_weight,
  input  logic signed [15:0] bias,
  output logic               m_valid,
  input  logic               m_ready,
  output logic signed [15:0] m_data,
  output logic               m_sat
);

  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int PROD_W    = DATA_W + COEF_W;
  localparam int FRAC_DROP = 12;
  localparam int CNT_W     = (TAPS > 1) ? $clog2(TAPS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAPS - 1);

`ifdef MAC_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(2048);
`else
  localparam logic signed [ACC_W-1:0] RND = '0;
`endif

  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] Q_MIN = -(ACC_W'(32768));

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_OUT   = 1'b1
  } state_t;

  function automatic logic signed [ACC_W-1:0] round_shift(
    input logic signed [ACC_W-1:0] a
  );
    logic signed [ACC_W-1:0] r;
    r = a + RND;
    return r >>> FRAC_DROP;
  endfunction

  // Returns {sat, data}.
  function automatic logic [DATA_W:0] saturate(
    input logic signed [ACC_W-1:0] q
  );
    if (q > Q_MAX)      return {1'b1, 16'h7FFF};
    else if (q < Q_MIN) return {1'b1, 16'h8000};
    else                return {1'b0, q[DATA_W-1:0]};
  endfunction

  state_t                    r_state;
  state_t                    w_state_next;
  logic        [CNT_W-1:0]   r_cnt;
  logic signed [ACC_W-1:0]   r_acc_p0;

  logic signed [PROD_W-1:0]  w_prod_p0;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_bias_ext;
  logic signed [ACC_W-1:0]   w_acc_base;
  logic signed [ACC_W-1:0]   w_acc_next;
  logic signed [ACC_W-1:0]   w_q;
  logic        [DATA_W:0]    w_sat_word;
  logic                      w_accept;
  logic                      w_last;

  // Stage p0: the product and the accumulator update for the current beat.
  assign w_prod_p0  = PROD_W'(s_data) * PROD_W'(s_weight);
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod_p0[PROD_W-1]}}, w_prod_p0};
  // Shifting the Q4.12 bias left by 12 aligns it with the Q8.24 products.
  assign w_bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} <<< FRAC_DROP;
  // The first beat of a group starts again from the bias, not from the old sum.
  assign w_acc_base = (r_cnt == '0) ? w_bias_ext : r_acc_p0;
  assign w_acc_next = w_acc_base + w_prod_ext;

  assign w_accept = s_valid && (r_state == ST_ACCUM);
  assign w_last   = w_accept && (r_cnt == CNT_LAST);

  // Requantise straight from the next sum, so the result is ready when OUT is entered.
  assign w_q        = round_shift(w_acc_next);
  assign w_sat_word = saturate(w_q);

  assign s_ready = (r_state == ST_ACCUM);
  assign m_valid = (r_state == ST_OUT);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ACCUM: if (w_last)  w_state_next = ST_OUT;
      ST_OUT:   if (m_ready) w_state_next = ST_ACCUM;
      default:               w_state_next = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_ACCUM;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc_p0 <= '0;
    end else if (w_accept) begin
      r_cnt    <= w_last ? '0 : r_cnt + CNT_W'(1);
      r_acc_p0 <= w_acc_next;
    end
  end

  // Stage p1: the output register, held through OUT until the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data <= '0;
      m_sat  <= 1'b0;
    end else if (w_last) begin
      {m_sat, m_data} <= w_sat_word;
    end
  end

endmodule

// File: tb/tb_conv_mac_requant.sv
module tb_conv_mac_requant;

  localparam int TAPS = 3;

  typedef logic [15:0] vec_t [TAPS];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        m_ready = 1'b0;
  logic [15:0] s_data = '0;
  logic [15:0] s_weight = '0;
  logic [15:0] bias = '0;
  logic        s_ready;
  logic        m_valid;
  logic        m_sat;
  logic [15:0] m_data;

  int n_vec = 0;
  int n_err = 0;
  logic [16:0] sb_q [$];

  always #5 clk = ~clk;

  conv_mac_requant #(.TAPS(TAPS), .ACC_W(40)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_weight (s_weight),
    .bias     (bias),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_sat    (m_sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_vec++;
    n_err++;
    $error("FAIL %s: observed timeout expected handshake", tag);
  endtask

  // Reference arithmetic: bias<<12 plus the products, then round or truncate, then saturate.
  function automatic logic [16:0] model(input logic [15:0] b, input vec_t d, input vec_t w);
    longint acc;
    longint q;
    acc = longint'($signed(b)) * 4096;
    for (int i = 0; i < TAPS; i++)
      acc += longint'($signed(d[i])) * longint'($signed(w[i]));
`ifdef MAC_ROUND_EN
    acc += 2048;
`endif
    q = acc >>> 12;
    if (q > 32767)       return {1'b1, 16'h7FFF};
    else if (q < -32768) return {1'b1, 16'h8000};
    else                 return {1'b0, q[15:0]};
  endfunction

  task automatic send_beat(input logic [15:0] d, input logic [15:0] w, input logic [15:0] b);
    int t;
    s_valid  = 1'b1;
    s_data   = d;
    s_weight = w;
    bias     = b;
    t = 0;
    while (!s_ready && t < 50) begin
      tick();
      t++;
    end
    if (t == 50) timeout_fail("s_ready_wait");
    tick();
  endtask

  task automatic send_group(input logic [15:0] b, input vec_t d, input vec_t w, input int gap_max);
    for (int i = 0; i < TAPS; i++) begin
      if (gap_max > 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(gap_max, 0)) tick();
      end
      // Only the first beat carries the real bias; later beats carry junk.
      send_beat(d[i], w[i], (i == 0) ? b : 16'($urandom));
    end
    s_valid = 1'b0;
    chk("latency_m_valid", 32'(m_valid), 32'd1);
  endtask

  task automatic collect(input string tag);
    int t;
    logic [16:0] exp;
    t = 0;
    while (!m_valid && t < 50) begin
      tick();
      t++;
    end
    if (t == 50) begin
      timeout_fail({tag, "_m_valid_wait"});
    end else if (sb_q.size() == 0) begin
      timeout_fail({tag, "_scoreboard_empty"});
    end else begin
      exp = sb_q.pop_front();
      chk({tag, "_data"}, 32'(m_data), 32'(exp[15:0]));
      chk({tag, "_sat"}, 32'(m_sat), 32'(exp[16]));
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
    end
  endtask

  task automatic run_directed(input string tag, input logic [15:0] b, input vec_t d,
                              input vec_t w, input logic [16:0] exp);
    sb_q.push_back(exp);
    send_group(b, d, w, 0);
    collect(tag);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_data"}, 32'(m_data), 32'd0);
    chk({tag, "_m_sat"}, 32'(m_sat), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t d, w, d2, w2;
    logic [16:0] exp_a, exp_b, e;
    logic [15:0] b;
    int outs;

    // Reset
    rst = 1'b1;
    tick();
    tick();
    chk_reset_outputs("por");
    rst = 1'b0;
    tick();

    // Nominal: 3 x 1.0*1.0 = 3.0
    d = '{16'h1000, 16'h1000, 16'h1000};
    w = '{16'h1000, 16'h1000, 16'h1000};
    run_directed("nominal", 16'h0000, d, w, {1'b0, 16'h3000});

    // Bias -1.0 plus 0.5 + 0.5 + 0 = 0
    d = '{16'h0800, 16'h0800, 16'h0000};
    w = '{16'h1000, 16'h1000, 16'h1000};
    run_directed("bias_neg", 16'hF000, d, w, {1'b0, 16'h0000});

    // Saturation in both directions
    d = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
    w = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
    run_directed("sat_pos", 16'h0000, d, w, {1'b1, 16'h7FFF});
    d = '{16'h8000, 16'h8000, 16'h8000};
    run_directed("sat_neg", 16'h0000, d, w, {1'b1, 16'h8000});

    // Rounding at the 12-bit drop
    d = '{16'hFFFF, 16'h0000, 16'h0000};
    w = '{16'h0001, 16'h0000, 16'h0000};
`ifdef MAC_ROUND_EN
    run_directed("round_m1", 16'h0000, d, w, {1'b0, 16'h0000});
`else
    run_directed("round_m1", 16'h0000, d, w, {1'b0, 16'hFFFF});
`endif
    d = '{16'h0001, 16'h0000, 16'h0000};
    w = '{16'h0800, 16'h0000, 16'h0000};
`ifdef MAC_ROUND_EN
    run_directed("round_half", 16'h0000, d, w, {1'b0, 16'h0001});
`else
    run_directed("round_half", 16'h0000, d, w, {1'b0, 16'h0000});
`endif

    // Backpressure: hold the output with the next group's first beat already offered
    d = '{16'h1000, 16'h1000, 16'h1000};
    w = '{16'h1000, 16'h1000, 16'h1000};
    exp_a = {1'b0, 16'h3000};
    sb_q.push_back(exp_a);
    send_group(16'h0000, d, w, 0);
    d2 = '{16'h1000, 16'h0800, 16'h0400};
    w2 = '{16'h2000, 16'h1000, 16'h1000};
    exp_b = {1'b0, 16'h2D00};
    s_valid  = 1'b1;
    s_data   = d2[0];
    s_weight = w2[0];
    bias     = 16'h0100;
    for (int c = 0; c < 10; c++) begin
      chk("hold_s_ready", 32'(s_ready), 32'd0);
      chk("hold_m_valid", 32'(m_valid), 32'd1);
      chk("hold_m_data", 32'(m_data), 32'(exp_a[15:0]));
      chk("hold_m_sat", 32'(m_sat), 32'(exp_a[16]));
      tick();
    end
    collect("hs_first");
    sb_q.push_back(exp_b);
    send_beat(d2[0], w2[0], 16'h0100);
    send_beat(d2[1], w2[1], 16'h7777);
    send_beat(d2[2], w2[2], 16'h8888);
    s_valid = 1'b0;
    collect("hs_next");

    // Random groups, gap-free and then with input gaps
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < TAPS; i++) begin
        d[i] = (k < 2) ? 16'($urandom_range(16'h1FFF, 0) - 16'h0FFF) : 16'($urandom);
        w[i] = (k < 2) ? 16'($urandom_range(16'h1FFF, 0) - 16'h0FFF) : 16'($urandom);
      end
      b = 16'($urandom);
      e = model(b, d, w);
      sb_q.push_back(e);
      send_group(b, d, w, 0);
      collect("rand_nogap");
      sb_q.push_back(e);
      send_group(b, d, w, 4);
      collect("rand_gap");
    end

    // Throughput: s_valid and m_ready held high, one output every TAPS+1 cycles
    d = '{16'h1000, 16'h1000, 16'h1000};
    for (int i = 0; i < 4; i++) sb_q.push_back({1'b0, 16'h3000});
    s_valid  = 1'b1;
    s_data   = 16'h1000;
    s_weight = 16'h1000;
    bias     = 16'h0000;
    m_ready  = 1'b1;
    outs = 0;
    for (int c = 0; c < 4 * (TAPS + 1); c++) begin
      tick();
      if (m_valid) begin
        outs++;
        if (sb_q.size() == 0) timeout_fail("tput_scoreboard_empty");
        else begin
          e = sb_q.pop_front();
          chk("tput_data", 32'(m_data), 32'(e[15:0]));
        end
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk("tput_outputs", 32'(outs), 32'd4);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset after beat 2 of a group
    send_beat(16'h4000, 16'h1000, 16'h2000);
    send_beat(16'h4000, 16'h1000, 16'h2000);
    s_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_midgroup");
    tick();
    chk_reset_outputs("rst_held");
    #2 rst = 1'b0;
    tick();
    d = '{16'h0800, 16'h0800, 16'h0800};
    w = '{16'h1000, 16'h1000, 16'h1000};
    run_directed("after_rst_group", 16'h0000, d, w, {1'b0, 16'h1800});

    // Reset while an output is pending
    d = '{16'h2000, 16'h2000, 16'h2000};
    send_beat(d[0], w[0], 16'h0000);
    send_beat(d[1], w[1], 16'h0000);
    send_beat(d[2], w[2], 16'h0000);
    s_valid = 1'b0;
    chk("pre_rst_out_valid", 32'(m_valid), 32'd1);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_midout");
    tick();
    #2 rst = 1'b0;
    tick();
    d = '{16'h1000, 16'h0000, 16'h0000};
    w = '{16'h1000, 16'h0000, 16'h0000};
    run_directed("after_rst_out", 16'h1000, d, w, {1'b0, 16'h2000});
    chk("sb_final_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
